// File: rtl/vl_async_pipe_pkg.sv
// ============================================================================
// Module : vl_async_pipe_pkg
// Brief  : Shared constants, count-update encoding and width helper for the pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vl_async_pipe_pkg;

    localparam int DEPTH_MAX = 8;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vl_async_pipe_stage.sv
// ============================================================================
// Module : vl_async_pipe_stage
// Brief  : One valid/data register pair with async reset, flush and source load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vl_async_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             src_valid_i,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             v_q;
    logic [WIDTH-1:0] d_q;

    // Data only moves with a valid source, so an empty stage keeps its last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else if (flush_i) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else if (load_i) begin
            v_q <= src_valid_i;
            if (src_valid_i) begin
                d_q <= src_data_i;
            end
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

`default_nettype wire

// File: rtl/vl_async_pipe.sv
// ============================================================================
// Module : vl_async_pipe
// Brief  : DEPTH-stage valid/ready pipeline with bubble collapse and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vl_async_pipe
    import vl_async_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [clog2(DEPTH+1)-1:0]       count
);

    localparam int CNT_W = clog2(DEPTH + 1);

    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d     [DEPTH];
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic             w_push;
    logic             w_pop;
    cnt_op_e          w_cnt_op;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Ready ripples from the output back; an empty stage is always ready.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = !w_v[i] | w_rdy[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_src_v[gi] = in_valid;
                assign w_src_d[gi] = in_data;
            end else begin : g_link
                assign w_src_v[gi] = w_v[gi-1];
                assign w_src_d[gi] = w_d[gi-1];
            end

            vl_async_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .flush_i     (flush),
                .load_i      (w_rdy[gi]),
                .src_valid_i (w_src_v[gi]),
                .src_data_i  (w_src_d[gi]),
                .valid_o     (w_v[gi]),
                .data_o      (w_d[gi])
            );
        end
    endgenerate

    assign w_push = in_valid & w_rdy[0];
    assign w_pop  = w_v[DEPTH-1] & out_ready;

    always_comb begin
        w_cnt_op = CNT_HOLD;
        if (w_push && !w_pop) begin
            w_cnt_op = CNT_INC;
        end else if (!w_push && w_pop) begin
            w_cnt_op = CNT_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        case (w_cnt_op)
            CNT_INC: count_d = count_q + CNT_W'(1);
            CNT_DEC: count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];
    assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_vl_async_pipe.sv
// ============================================================================
// Module : tb_vl_async_pipe
// Brief  : Directed self-checking bench for vl_async_pipe (DEPTH=3, WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vl_async_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] count;

    int total = 0;
    int bad   = 0;

    // Expected values for the back-to-back stream, one entry per clock edge.
    logic [1:0] s_cnt  [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic       s_vld  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] s_dat  [8] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};

    vl_async_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== RV) begin bad++; $display("FAIL reset_data got=%h exp=%h", out_data, RV); end
        total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_inready got=%b exp=1", in_ready); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            in_data  = 8'(c + 1);
            if (c < 5) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_inready c=%0d got=%b exp=1", c, in_ready); end
            end
            tick();
            total++; if (count !== s_cnt[c]) begin bad++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count, s_cnt[c]); end
            total++; if (out_valid !== s_vld[c]) begin bad++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, s_vld[c]); end
            if (s_vld[c]) begin
                total++; if (out_data !== s_dat[c]) begin bad++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, out_data, s_dat[c]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_full();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 + k);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_accept k=%0d got=%b exp=1", k, in_ready); end
            tick();
        end
        in_data = 8'h14;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_inready got=%b exp=0", in_ready); end
        total++; if (count !== 2'd3) begin bad++; $display("FAIL full_count got=%0d exp=3", count); end
        tick();
        total++; if (count !== 2'd3 || out_data !== 8'h11) begin bad++; $display("FAIL full_hold count=%0d data=%h exp 3/11", count, out_data); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pushpop_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (count !== 2'd3 || out_data !== 8'h12) begin bad++; $display("FAIL full_pushpop count=%0d data=%h exp 3/12", count, out_data); end
        tick();
        total++; if (count !== 2'd2 || out_data !== 8'h13) begin bad++; $display("FAIL full_drain1 count=%0d data=%h exp 2/13", count, out_data); end
        tick();
        total++; if (count !== 2'd1 || out_data !== 8'h14 || out_valid !== 1'b1) begin bad++; $display("FAIL full_drain2 count=%0d data=%h valid=%b exp 1/14/1", count, out_data, out_valid); end
        tick();
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL full_empty count=%0d valid=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (count !== 2'd1 || out_valid !== 1'b1 || out_data !== 8'h21) begin bad++; $display("FAIL bubble_seed count=%0d valid=%b data=%h exp 1/1/21", count, out_valid, out_data); end
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h22 + k);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_accept k=%0d got=%b exp=1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        total++; if (count !== 2'd3 || out_data !== 8'h21) begin bad++; $display("FAIL bubble_full count=%0d data=%h exp 3/21", count, out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 8'h22) begin bad++; $display("FAIL bubble_order1 got=%h exp=22", out_data); end
        tick();
        total++; if (out_data !== 8'h23) begin bad++; $display("FAIL bubble_order2 got=%h exp=23", out_data); end
        tick();
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL bubble_empty count=%0d valid=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + k);
            tick();
        end
        total++; if (count !== 2'd3) begin bad++; $display("FAIL flush_prefill count=%0d exp=3", count); end
        flush     = 1'b1;
        in_data   = 8'h34;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== RV) begin bad++; $display("FAIL flush_data got=%h exp=%h", out_data, RV); end
        tick();
        tick();
        total++; if (count !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_lost count=%0d valid=%b exp 0/0", count, out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h42;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h41) begin bad++; $display("FAIL areset_pre count=%0d valid=%b data=%h exp 2/1/41", count, out_valid, out_data); end
        #2 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        total++; if (count !== 2'd0 || out_data !== RV) begin bad++; $display("FAIL areset_state count=%0d data=%h exp 0/%h", count, out_data, RV); end
        #1 reset = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_early got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h3C || count !== 2'd1) begin bad++; $display("FAIL areset_word valid=%b data=%h count=%0d exp 1/3c/1", out_valid, out_data, count); end
        tick();
        total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL areset_drain valid=%b count=%0d exp 0/0", out_valid, count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_bubble();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
